// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fft_pkg
// Description : Definitions shared by the FFT stage sequencer:
//               - LOG2N_W : width of the cfg_log2n field
//               - LOG2N_MIN : smallest legal log2 transform length
//               - seq_state_t : sequencer state encoding
//               - log2n_legal() : range check used when a start arrives
// Revision    : 1.0 - initial release
// ============================================================================
package fft_pkg;

  localparam int LOG2N_W   = 5;
  localparam int LOG2N_MIN = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_FINISH = 2'd3
  } seq_state_t;

  // The upper limit is the address width of the instantiating block, so it is
  // passed in rather than fixed here.
  function automatic logic log2n_legal(input logic [LOG2N_W-1:0] log2n,
                                       input int unsigned        max_log2n);
    return (int'(log2n) >= LOG2N_MIN) && (int'(log2n) <= int'(max_log2n));
  endfunction

endpackage
`default_nettype wire

// File: rtl/fft_seq_delay.sv
`default_nettype none
// ============================================================================
// Module      : fft_seq_delay
// Description : Fixed-depth register delay line. dout is din delayed by
//               exactly DEPTH clock cycles; every stage clears on reset.
// Ports       : clk, rst_n (async, active-low)
//               din  [WIDTH-1:0] : value entering the line
//               dout [WIDTH-1:0] : value leaving the line
// Revision    : 1.0 - initial release
// ============================================================================
module fft_seq_delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] r_pipe [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_pipe[i] <= '0;
      end
    end else begin
      r_pipe[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  assign dout = r_pipe[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/fft_stage_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fft_stage_sequencer
// Description : Address/control sequencer for an in-place radix-2 FFT.
//               Issues N/2 butterflies per stage (one per cycle), aligns the
//               butterfly controls to memory read data, registers write-back
//               addresses, and holds each new stage until every write of the
//               previous stage has landed.
// Ports       : clk, rst_n (async, active-low)
//               start, cfg_log2n          : transform request / log2 length
//               busy, done, cfg_err       : status
//               rd_en, rd_addr_a/b        : operand read
//               mult_en, first_lev_s,
//               fft_i_index, tw_addr      : butterfly controls (read-aligned)
//               bf_out_vld, fft_o_index   : butterfly result return
//               wr_en, wr_addr_a/b        : in-place write-back
// Revision    : 1.0 - initial release
// ============================================================================
module fft_stage_sequencer
  import fft_pkg::*;
#(
  parameter int ADDR_WIDTH    = 10,
  parameter int MEM_RD_LAT    = 1,
  parameter int BUTTERFLY_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [LOG2N_W-1:0]    cfg_log2n,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_err,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr_a,
  output logic [ADDR_WIDTH-1:0] rd_addr_b,
  output logic                  mult_en,
  output logic                  first_lev_s,
  output logic [ADDR_WIDTH-1:0] fft_i_index,
  output logic [ADDR_WIDTH-2:0] tw_addr,
  input  logic                  bf_out_vld,
  input  logic [ADDR_WIDTH-1:0] fft_o_index,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr_a,
  output logic [ADDR_WIDTH-1:0] wr_addr_b
);

  localparam int TW_W   = ADDR_WIDTH - 1;
  localparam int INFL_W = $clog2(MEM_RD_LAT + BUTTERFLY_LAT + 3);
  localparam int DL_W   = 2 + ADDR_WIDTH + TW_W;

  localparam logic [INFL_W-1:0] C_INFL_MAX = '1;

  // --------------------------------------------------------------------------
  // Butterfly address arithmetic for stage s, butterfly k
  // --------------------------------------------------------------------------
  function automatic logic [ADDR_WIDTH-1:0] addr_a_of(input logic [LOG2N_W-1:0]    s,
                                                      input logic [ADDR_WIDTH-1:0] k);
    logic [ADDR_WIDTH-1:0] p;
    logic [ADDR_WIDTH-1:0] g;
    p = k & ((ADDR_WIDTH'(1) << s) - ADDR_WIDTH'(1));
    g = k >> s;
    return (g << (int'(s) + 1)) | p;
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] addr_b_of(input logic [LOG2N_W-1:0]    s,
                                                      input logic [ADDR_WIDTH-1:0] k);
    return addr_a_of(s, k) + (ADDR_WIDTH'(1) << s);
  endfunction

  // Stage s never exceeds ADDR_WIDTH-1 while issuing, so the shift is >= 0.
  function automatic logic [TW_W-1:0] tw_of(input logic [LOG2N_W-1:0]    s,
                                            input logic [ADDR_WIDTH-1:0] k);
    logic [ADDR_WIDTH-1:0] p;
    p = k & ((ADDR_WIDTH'(1) << s) - ADDR_WIDTH'(1));
    return TW_W'(p << (TW_W - int'(s)));
  endfunction

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  seq_state_t            r_state;
  logic [LOG2N_W-1:0]    r_log2n;
  logic [LOG2N_W-1:0]    r_stage;
  logic [ADDR_WIDTH-1:0] r_k;
  logic [ADDR_WIDTH-1:0] r_k_last;
  logic [INFL_W-1:0]     r_inflight;

  logic                  w_cfg_ok;
  logic                  w_bf_accept;
  logic [INFL_W-1:0]     w_inflight_nxt;
  logic [DL_W-1:0]       w_dl_in;
  logic [DL_W-1:0]       w_dl_out;

  assign w_cfg_ok = log2n_legal(cfg_log2n, ADDR_WIDTH);

  // A result arriving with nothing outstanding is a protocol error: drop it.
  assign w_bf_accept = bf_out_vld && (r_inflight != '0);

  // Outstanding-butterfly count, saturating at both ends.
  always_comb begin
    w_inflight_nxt = r_inflight;
    if (rd_en && !wr_en && (r_inflight != C_INFL_MAX)) begin
      w_inflight_nxt = r_inflight + 1'b1;
    end else if (!rd_en && wr_en && (r_inflight != '0)) begin
      w_inflight_nxt = r_inflight - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inflight <= '0;
    end else begin
      r_inflight <= w_inflight_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Sequencer FSM. rd_en and the read addresses are registered alongside the
  // state, so rd_en is high exactly in ISSUE and r_k is the butterfly whose
  // addresses are on rd_addr_a/b in that cycle.
  //
  // DRAIN exits on the count as it will be after this cycle: when the last
  // write-back is on wr_en now, the next stage starts reading (or done is
  // raised) in the very next cycle, which is still strictly after the write.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_log2n   <= '0;
      r_stage   <= '0;
      r_k       <= '0;
      r_k_last  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cfg_err   <= 1'b0;
      rd_en     <= 1'b0;
      rd_addr_a <= '0;
      rd_addr_b <= '0;
    end else begin
      done    <= 1'b0;
      cfg_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            if (w_cfg_ok) begin
              r_state   <= ST_ISSUE;
              r_log2n   <= cfg_log2n;
              r_stage   <= '0;
              r_k       <= '0;
              r_k_last  <= (ADDR_WIDTH'(1) << (cfg_log2n - 1'b1)) - ADDR_WIDTH'(1);
              busy      <= 1'b1;
              rd_en     <= 1'b1;
              rd_addr_a <= addr_a_of('0, '0);
              rd_addr_b <= addr_b_of('0, '0);
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end

        ST_ISSUE: begin
          if (r_k == r_k_last) begin
            r_state   <= ST_DRAIN;
            rd_en     <= 1'b0;
            rd_addr_a <= '0;
            rd_addr_b <= '0;
          end else begin
            r_k       <= r_k + 1'b1;
            rd_en     <= 1'b1;
            rd_addr_a <= addr_a_of(r_stage, r_k + 1'b1);
            rd_addr_b <= addr_b_of(r_stage, r_k + 1'b1);
          end
        end

        ST_DRAIN: begin
          if (w_inflight_nxt == '0) begin
            if (r_stage == (r_log2n - 1'b1)) begin
              r_state <= ST_FINISH;
              done    <= 1'b1;
              busy    <= 1'b0;
            end else begin
              r_state   <= ST_ISSUE;
              r_stage   <= r_stage + 1'b1;
              r_k       <= '0;
              rd_en     <= 1'b1;
              rd_addr_a <= addr_a_of(r_stage + 1'b1, '0);
              rd_addr_b <= addr_b_of(r_stage + 1'b1, '0);
            end
          end
        end

        ST_FINISH: begin
          r_state <= ST_IDLE;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Butterfly controls, delayed to line up with the memory read data
  // --------------------------------------------------------------------------
  assign w_dl_in = rd_en ? {1'b1, (r_stage == '0), r_k, tw_of(r_stage, r_k)} : '0;

  fft_seq_delay #(
    .WIDTH (DL_W),
    .DEPTH (MEM_RD_LAT)
  ) u_ctl_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (w_dl_in),
    .dout  (w_dl_out)
  );

  assign mult_en     = w_dl_out[DL_W-1];
  assign first_lev_s = w_dl_out[DL_W-2];
  assign fft_i_index = w_dl_out[TW_W +: ADDR_WIDTH];
  assign tw_addr     = w_dl_out[TW_W-1:0];

  // --------------------------------------------------------------------------
  // Write-back. The stage cannot advance while results are outstanding, so
  // r_stage is still the stage that produced the returned index.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en     <= 1'b0;
      wr_addr_a <= '0;
      wr_addr_b <= '0;
    end else begin
      wr_en <= w_bf_accept;
      if (w_bf_accept) begin
        wr_addr_a <= addr_a_of(r_stage, fft_o_index);
        wr_addr_b <= addr_b_of(r_stage, fft_o_index);
      end else begin
        wr_addr_a <= '0;
        wr_addr_b <= '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fft_stage_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fft_stage_sequencer
// Description : Self-checking bench for fft_stage_sequencer with a behavioural
//               butterfly model and an expected-butterfly reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fft_stage_sequencer;

  localparam int AW = 10;
  localparam int ML = 2;
  localparam int BL = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [4:0]    cfg_log2n = '0;
  logic          busy, done, cfg_err, rd_en, mult_en, first_lev_s, wr_en;
  logic [AW-1:0] rd_addr_a, rd_addr_b, fft_i_index, wr_addr_a, wr_addr_b;
  logic [AW-2:0] tw_addr;
  logic          bf_out_vld;
  logic [AW-1:0] fft_o_index;
  logic          inj_vld = 1'b0;

  fft_stage_sequencer #(
    .ADDR_WIDTH    (AW),
    .MEM_RD_LAT    (ML),
    .BUTTERFLY_LAT (BL)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .cfg_log2n   (cfg_log2n),
    .busy        (busy),
    .done        (done),
    .cfg_err     (cfg_err),
    .rd_en       (rd_en),
    .rd_addr_a   (rd_addr_a),
    .rd_addr_b   (rd_addr_b),
    .mult_en     (mult_en),
    .first_lev_s (first_lev_s),
    .fft_i_index (fft_i_index),
    .tw_addr     (tw_addr),
    .bf_out_vld  (bf_out_vld),
    .fft_o_index (fft_o_index),
    .wr_en       (wr_en),
    .wr_addr_a   (wr_addr_a),
    .wr_addr_b   (wr_addr_b)
  );

  always #5 clk = ~clk;

  // Butterfly model: returns each index BL cycles after mult_en.
  logic [BL-1:0] bf_v_pipe;
  logic [AW-1:0] bf_i_pipe [BL];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bf_v_pipe <= '0;
      for (int i = 0; i < BL; i++) bf_i_pipe[i] <= '0;
    end else begin
      bf_v_pipe <= {bf_v_pipe[BL-2:0], mult_en};
      bf_i_pipe[0] <= fft_i_index;
      for (int i = 1; i < BL; i++) bf_i_pipe[i] <= bf_i_pipe[i-1];
    end
  end

  assign bf_out_vld  = bf_v_pipe[BL-1] | inj_vld;
  assign fft_o_index = bf_i_pipe[BL-1];

  // --------------------------------------------------------------------------
  // Checking
  // --------------------------------------------------------------------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  // --------------------------------------------------------------------------
  // Reference model: expected butterflies of one transform, in issue order
  // --------------------------------------------------------------------------
  typedef struct {
    int a;
    int b;
    int tw;
    int k;
    int first;
    int stage;
  } bfly_t;

  bfly_t exp_rd_q[$];
  bfly_t exp_ctl_q[$];
  bfly_t exp_wr_q[$];
  int    rd_cyc_q[$];

  int cyc = 0;
  int n_rd, n_mult, n_wr, last_wr_cyc, done_cnt, half, cur_l;
  bit mon_en = 1'b0;
  int cap_a [12];
  int cap_b [12];
  int cap_tw [12];
  int cap_first [12];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic build_model(input int l);
    bfly_t e;
    exp_rd_q.delete(); exp_ctl_q.delete(); exp_wr_q.delete(); rd_cyc_q.delete();
    cur_l = l; half = 1 << (l - 1);
    n_rd = 0; n_mult = 0; n_wr = 0; done_cnt = 0; last_wr_cyc = 0;
    for (int s = 0; s < l; s++) begin
      for (int k = 0; k < half; k++) begin
        int h;
        h       = 1 << s;
        e.a     = (k / h) * (2 * h) + (k % h);
        e.b     = e.a + h;
        e.tw    = (k % h) * ((1 << (AW - 1)) / h);
        e.k     = k;
        e.first = (s == 0) ? 1 : 0;
        e.stage = s;
        exp_rd_q.push_back(e);
      end
    end
  endtask

  bfly_t mon_e;
  int    mon_c;

  always @(negedge clk) begin
    if (mon_en) begin
      // Reads are handled before writes so a read in the same cycle as the
      // last write of the previous stage counts as a hazard.
      if (rd_en) begin
        if (exp_rd_q.size() == 0) chk("unexpected_rd_en", 1, 0);
        else begin
          mon_e = exp_rd_q.pop_front();
          chk("rd_addr_a", rd_addr_a, mon_e.a);
          chk("rd_addr_b", rd_addr_b, mon_e.b);
          chk("raw_order", (n_wr >= mon_e.stage * half) ? 1 : 0, 1);
          if (cur_l == 3 && n_rd < 12) begin
            cap_a[n_rd] = int'(rd_addr_a);
            cap_b[n_rd] = int'(rd_addr_b);
          end
          exp_ctl_q.push_back(mon_e);
          exp_wr_q.push_back(mon_e);
          rd_cyc_q.push_back(cyc);
          n_rd++;
        end
      end
      if (mult_en) begin
        if (exp_ctl_q.size() == 0) chk("unexpected_mult_en", 1, 0);
        else begin
          mon_e = exp_ctl_q.pop_front();
          mon_c = rd_cyc_q.pop_front();
          chk("mult_latency", cyc - mon_c, ML);
          chk("fft_i_index", fft_i_index, mon_e.k);
          chk("tw_addr", tw_addr, mon_e.tw);
          chk("first_lev_s", first_lev_s, mon_e.first);
          if (cur_l == 3 && n_mult < 12) begin
            cap_tw[n_mult]    = int'(tw_addr);
            cap_first[n_mult] = int'(first_lev_s);
          end
          n_mult++;
        end
      end
      if (wr_en) begin
        if (exp_wr_q.size() == 0) chk("unexpected_wr_en", 1, 0);
        else begin
          mon_e = exp_wr_q.pop_front();
          chk("wr_addr_a", wr_addr_a, mon_e.a);
          chk("wr_addr_b", wr_addr_b, mon_e.b);
          n_wr++;
          last_wr_cyc = cyc;
        end
      end
      if (done) begin
        chk("done_expected",
            (cur_l != 0 && exp_rd_q.size() == 0 && n_wr == cur_l * half) ? 1 : 0, 1);
        chk("done_after_last_wr", cyc - last_wr_cyc, 1);
        chk("busy_low_at_done", busy, 0);
        done_cnt++;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus tasks
  // --------------------------------------------------------------------------
  task automatic run_xform(input int l, input bit poke_busy);
    int budget;
    build_model(l);
    @(negedge clk);
    start = 1'b1; cfg_log2n = 5'(l);
    @(negedge clk);
    start = 1'b0; cfg_log2n = 5'($urandom_range(0, 31));
    chk("busy_after_start", busy, 1);
    chk("no_cfg_err_legal", cfg_err, 0);
    if (poke_busy) begin
      repeat (2) @(negedge clk);
      start = 1'b1; cfg_log2n = 5'($urandom_range(2, AW));
      @(negedge clk);
      start = 1'b0;
    end
    budget = l * (half + 20) + 50;
    for (int i = 0; i < budget && done_cnt == 0; i++) @(negedge clk);
    chk("done_count", done_cnt, 1);
    chk("reads_consumed", exp_rd_q.size(), 0);
    chk("write_count", n_wr, l * half);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("busy_after_done", busy, 0);
  endtask

  task automatic bad_cfg(input int v);
    @(negedge clk);
    start = 1'b1; cfg_log2n = 5'(v);
    @(negedge clk);
    start = 1'b0;
    chk("cfg_err_pulse", cfg_err, 1);
    chk("cfg_err_busy", busy, 0);
    repeat (2) @(negedge clk);
    chk("cfg_err_single", cfg_err, 0);
    chk("cfg_err_busy_stays", busy, 0);
  endtask

  int ref_a3 [12]  = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
  int ref_b3 [12]  = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
  int ref_tw3 [12] = '{0, 0, 0, 0, 0, 256, 0, 256, 0, 128, 256, 384};

  initial begin
    cur_l = 0; half = 1;
    #12;
    chk("reset_outputs_zero",
        ({busy, done, cfg_err, rd_en, rd_addr_a, rd_addr_b, mult_en, first_lev_s,
          fft_i_index, tw_addr, wr_en, wr_addr_a, wr_addr_b} == '0) ? 1 : 0, 1);
    @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;
    repeat (2) @(negedge clk);

    // Fixed 8-point transform against literal address tables.
    run_xform(3, 1'b0);
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("n8_a[%0d]", i), cap_a[i], ref_a3[i]);
      chk($sformatf("n8_b[%0d]", i), cap_b[i], ref_b3[i]);
      chk($sformatf("n8_tw[%0d]", i), cap_tw[i], ref_tw3[i]);
      chk($sformatf("n8_first[%0d]", i), cap_first[i], (i < 4) ? 1 : 0);
    end

    // Illegal lengths.
    bad_cfg(1);
    bad_cfg(11);
    bad_cfg(0);
    bad_cfg($urandom_range(12, 31));

    // Stray butterfly result while idle must be dropped.
    @(negedge clk); inj_vld = 1'b1;
    @(negedge clk); inj_vld = 1'b0;
    chk("stray_vld_no_wr", wr_en, 0);

    // Start while busy must not disturb the running transform.
    run_xform(4, 1'b1);
    run_xform(2, 1'b0);
    run_xform(AW, 1'b0);

    // Randomized lengths and gaps.
    for (int r = 0; r < 8; r++) begin
      repeat ($urandom_range(0, 5)) @(negedge clk);
      run_xform($urandom_range(2, 7), 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of stage 1.
    build_model(3);
    @(negedge clk);
    start = 1'b1; cfg_log2n = 5'd3;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 200 && n_rd < 6; i++) @(negedge clk);
    chk("reached_stage1", (n_rd >= 6) ? 1 : 0, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_outputs_zero",
        ({busy, done, cfg_err, rd_en, rd_addr_a, rd_addr_b, mult_en, first_lev_s,
          fft_i_index, tw_addr, wr_en, wr_addr_a, wr_addr_b} == '0) ? 1 : 0, 1);
    mon_en = 1'b0;
    repeat (3) @(negedge clk);
    build_model(3);
    exp_rd_q.delete();
    cur_l = 0;
    rst_n = 1'b1;
    mon_en = 1'b1;
    repeat (10) @(negedge clk);
    chk("no_done_after_reset", done_cnt, 0);
    run_xform(2, 1'b0);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fft_stage_sequencer.md
FFT_STAGE_SEQUENCER -- requirements
Module: fft_stage_sequencer

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, meaning log2 of the maximum transform length (memory address width).
REQ-002 SHALL have parameter MEM_RD_LAT, default 1, meaning data-memory read latency in cycles (1..4).
REQ-003 SHALL have parameter BUTTERFLY_LAT, default 1, meaning butterfly latency from mult_en to dat_out_vld (1..4).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port start, input, 1 bit: single-cycle request to begin one transform.
REQ-007 SHALL have port cfg_log2n, input, 5 bits: log2 of transform length, sampled only on an accepted start.
REQ-008 SHALL have port busy, output, 1 bit: high from the cycle after start is accepted until done.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse when the transform completes.
REQ-010 SHALL have port cfg_err, output, 1 bit: one-cycle pulse when start is rejected for an illegal cfg_log2n.
REQ-011 SHALL have port rd_en, output, 1 bit: read strobe for the a/b operand pair.
REQ-012 SHALL have ports rd_addr_a and rd_addr_b, outputs, ADDR_WIDTH bits each: operand read addresses.
REQ-013 SHALL have ports mult_en, first_lev_s, fft_i_index, and tw_addr, outputs, widths 1, 1, ADDR_WIDTH, and ADDR_WIDTH-1: butterfly controls, aligned to read data.
REQ-014 SHALL have ports bf_out_vld and fft_o_index, inputs, widths 1 and ADDR_WIDTH: butterfly result valid and returned butterfly index.
REQ-015 SHALL have ports wr_en, wr_addr_a, and wr_addr_b, outputs, widths 1, ADDR_WIDTH, and ADDR_WIDTH: write-back strobe and in-place addresses.

Function
REQ-016 SHALL implement the states IDLE, ISSUE, DRAIN and FINISH:
- start accepted in IDLE -> ISSUE;
- ISSUE at k = N/2-1 -> DRAIN;
- DRAIN with inflight = 0 and stage < L-1 -> ISSUE, with stage+1 and k = 0;
- DRAIN with inflight = 0 and stage = L-1 -> FINISH;
- FINISH -> IDLE.
REQ-017 SHALL accept start only in IDLE with 2 <= cfg_log2n <= ADDR_WIDTH, latching L = cfg_log2n and N = 2^L.
REQ-018 SHALL ignore start while busy; an out-of-range cfg_log2n SHALL pulse cfg_err for one cycle and remain in IDLE.
REQ-019 SHALL assert rd_en in every ISSUE cycle, issuing one butterfly k per cycle (k = 0..N/2-1), so a stage issues in N/2 cycles.
REQ-020 SHALL compute addresses from stage s with h = 2^s, g = k>>s, p = k&(h-1):
- rd_addr_a = (g<<(s+1)) | p;
- rd_addr_b = rd_addr_a + h;
- tw_addr = p<<(ADDR_WIDTH-1-s).
REQ-021 SHALL drive mult_en, fft_i_index (= k), tw_addr and first_lev_s (= stage 0) exactly MEM_RD_LAT cycles after the matching rd_en.
REQ-022 SHALL register write-back one cycle after bf_out_vld:
- wr_en <= bf_out_vld;
- wr_addr_a/b are recomputed from fft_o_index and the current stage with the REQ-020 formula.
REQ-023 SHALL keep a counter inflight that is +1 on rd_en and -1 on wr_en, unchanged when both occur in the same cycle, and never wraps.
REQ-024 SHALL gate DRAIN exit on inflight = 0, so no read of stage s+1 precedes the last write of stage s (RAW hazard).
REQ-025 SHALL pulse done in FINISH exactly one cycle after the final wr_en, with busy falling in the same cycle.
REQ-026 SHALL size inflight at clog2(MEM_RD_LAT+BUTTERFLY_LAT+3) bits.
REQ-027 SHALL treat bf_out_vld while inflight = 0 as a protocol error: it is ignored, with no wr_en and no counter underflow.

Reset
REQ-028 SHALL, on rst_n low, immediately force:
- state = IDLE and the stage, k and inflight counters to 0;
- every delay-line stage to 0;
- every output to 0.
REQ-029 SHALL, on reset mid-transform, abandon the transform without emitting done; the first start after release begins from stage 0.

Structure
REQ-030 SHALL take the state encoding, LOG2N_W = 5 and the legal-range limits from the shared fft_pkg definitions.
REQ-031 SHALL instantiate a sub-module fft_seq_delay: a parameterized width×depth register delay line with asynchronous reset, used for the MEM_RD_LAT control alignment.

Verification
REQ-032 SHALL verify, at ADDR_WIDTH=10 and cfg_log2n=3, stage 0: rd_addr_a = 0,2,4,6; rd_addr_b = 1,3,5,7; tw_addr = 0,0,0,0; first_lev_s = 1.
REQ-033 SHALL verify, same run, stage 1: a = 0,1,4,5; b = 2,3,6,7; tw = 0,256,0,256. Stage 2: a = 0,1,2,3; b = 4,5,6,7; tw = 0,128,256,384.
REQ-034 SHALL verify, with BUTTERFLY_LAT=3 and MEM_RD_LAT=2, that no stage-(s+1) rd_en occurs before the last stage-s wr_en, and that done fires one cycle after the 12th wr_en.
REQ-035 SHALL verify that cfg_log2n=1 or 11 -> cfg_err pulse, busy stays 0 and no rd_en; and that start while busy -> no effect on addresses.
REQ-036 SHALL verify that asserting rst_n low during stage 1 -> all outputs 0 at once, no done; a later start at cfg_log2n=2 completes with 4 writes.
